// File: rtl/vga_pkg.sv
// Shared constants, FSM encoding and small helpers for the VGA ball blocks.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned REG_W        = 8;
  localparam int unsigned ADDR_W       = 3;

  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DX   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_DY   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_SXL  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SXH  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_SYL  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_SYH  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_FCNT = 3'd7;

  typedef enum logic {IDLE, STEP} motion_state_t;

  // Clamp a staged coordinate into the bounce window.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input logic [COORD_W-1:0] lo,
                                                     input logic [COORD_W-1:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // -128 has no positive counterpart, so it would break reflection; store -127.
  function automatic logic [REG_W-1:0] sat_vel(input logic [REG_W-1:0] v);
    return (v == 8'h80) ? 8'h81 : v;
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis reflect/clamp: advances pos by d and bounces off [MIN, MAX].
module axis_step
  import vga_pkg::*;
#(
  parameter int unsigned MIN = 70,
  parameter int unsigned MAX = 569
) (
  input  logic        [COORD_W-1:0] pos,
  input  logic signed [REG_W-1:0]   d,
  output logic        [COORD_W-1:0] next_pos,
  output logic signed [REG_W-1:0]   next_d
);

  localparam logic signed [11:0] MIN_S = 12'(MIN);
  localparam logic signed [11:0] MAX_S = 12'(MAX);

  logic signed [11:0] n;

  always_comb begin
    n        = $signed({2'b00, pos}) + $signed({{4{d[7]}}, d});
    next_pos = pos;
    next_d   = d;
    if (n < MIN_S) begin
      next_pos = COORD_W'(MIN);
      next_d   = -d;
    end else if (n > MAX_S) begin
      next_pos = COORD_W'(MAX);
      next_d   = -d;
    end else begin
      next_pos = n[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/vga_ball_motion.sv
// Frame-synchronous ball position engine with an 8-bit register slave.
module vga_ball_motion
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned RADIUS   = 70
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               write,
  input  logic               read,
  input  logic [ADDR_W-1:0]  address,
  input  logic [REG_W-1:0]   writedata,
  output logic [REG_W-1:0]   readdata,
  input  logic               frame_tick,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic               busy
);

  localparam int unsigned XMIN = RADIUS;
  localparam int unsigned XMAX = H_ACTIVE - 1 - RADIUS;
  localparam int unsigned YMIN = RADIUS;
  localparam int unsigned YMAX = V_ACTIVE - 1 - RADIUS;

  motion_state_t state, next_state;

  logic                      enable, load_pending;
  logic signed [REG_W-1:0]   dx, dy;
  logic        [COORD_W-1:0] sx, sy;
  logic        [REG_W-1:0]   frame_cnt;
  logic        [COORD_W-1:0] nx, ny;
  logic signed [REG_W-1:0]   ndx, ndy;
  logic        [REG_W-1:0]   rdata_c;

  axis_step #(.MIN(XMIN), .MAX(XMAX)) u_x (.pos(ball_x), .d(dx), .next_pos(nx), .next_d(ndx));
  axis_step #(.MIN(YMIN), .MAX(YMAX)) u_y (.pos(ball_y), .d(dy), .next_pos(ny), .next_d(ndy));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Ticks arriving while in STEP are dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_tick) next_state = STEP;
      STEP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state == STEP);

  always_comb begin
    rdata_c = '0;
    case (address)
      ADDR_CTRL: rdata_c = {6'b0, load_pending, enable};
      ADDR_DX:   rdata_c = dx;
      ADDR_DY:   rdata_c = dy;
      ADDR_SXL:  rdata_c = ball_x[7:0];
      ADDR_SXH:  rdata_c = {6'b0, ball_x[9:8]};
      ADDR_SYL:  rdata_c = ball_y[7:0];
      ADDR_SYH:  rdata_c = {6'b0, ball_y[9:8]};
      ADDR_FCNT: rdata_c = frame_cnt;
      default:   rdata_c = '0;
    endcase
  end

  // Frame update first, then software writes so a same-edge write wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x       <= COORD_W'(H_ACTIVE / 2);
      ball_y       <= COORD_W'(V_ACTIVE / 2);
      dx           <= '0;
      dy           <= '0;
      sx           <= COORD_W'(H_ACTIVE / 2);
      sy           <= COORD_W'(V_ACTIVE / 2);
      enable       <= 1'b0;
      load_pending <= 1'b0;
      frame_cnt    <= '0;
      readdata     <= '0;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + 8'd1;

      if (state == STEP) begin
        if (load_pending) begin
          ball_x       <= clamp_coord(sx, COORD_W'(XMIN), COORD_W'(XMAX));
          ball_y       <= clamp_coord(sy, COORD_W'(YMIN), COORD_W'(YMAX));
          load_pending <= 1'b0;
        end else if (enable) begin
          ball_x <= nx;
          ball_y <= ny;
          dx     <= ndx;
          dy     <= ndy;
        end
      end

      if (chipselect && write) begin
        case (address)
          ADDR_CTRL: begin
            enable <= writedata[0];
            if (writedata[1]) load_pending <= 1'b1;
          end
          ADDR_DX:  dx       <= sat_vel(writedata);
          ADDR_DY:  dy       <= sat_vel(writedata);
          ADDR_SXL: sx[7:0]  <= writedata;
          ADDR_SXH: sx[9:8]  <= writedata[1:0];
          ADDR_SYL: sy[7:0]  <= writedata;
          ADDR_SYH: sy[9:8]  <= writedata[1:0];
          default: ;
        endcase
      end

      if (chipselect && read) readdata <= rdata_c;
    end
  end

endmodule

// File: tb/tb_vga_ball_motion.sv
// Directed bench for vga_ball_motion with hand-computed expectations.
module tb_vga_ball_motion;

  logic       clk = 1'b0;
  logic       reset;
  logic       chipselect, write, read, frame_tick;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic [9:0] ball_x, ball_y;
  logic       busy;
  logic [7:0] rv;

  int checks   = 0;
  int failures = 0;

  vga_ball_motion dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .frame_tick(frame_tick), .ball_x(ball_x), .ball_y(ball_y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cyc();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    cyc();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  // Tick at edge k, let the STEP edge k+1 pass.
  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    frame_tick = 1'b0; address = '0; writedata = '0;

    // Reset applied before any clock edge
    #2;
    chk("rst_ball_x", 32'(ball_x), 320);
    chk("rst_ball_y", 32'(ball_y), 240);
    chk("rst_readdata", 32'(readdata), 0);
    chk("rst_busy", 32'(busy), 0);
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    rd(3'd7, rv); chk("rst_fcnt", 32'(rv), 0);

    // Free motion
    wr(3'd1, 8'd5);
    wr(3'd2, 8'hFD);
    wr(3'd0, 8'h01);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("free_busy_hi", 32'(busy), 1);
    chk("free_x_hold", 32'(ball_x), 320);
    cyc();
    chk("free_busy_lo", 32'(busy), 0);
    chk("free_x", 32'(ball_x), 325);
    chk("free_y", 32'(ball_y), 237);
    rd(3'd7, rv); chk("free_fcnt", 32'(rv), 1);

    // Right-edge bounce
    wr(3'd3, 8'h35);
    wr(3'd4, 8'h02);
    wr(3'd1, 8'd10);
    wr(3'd0, 8'h03);
    tick();
    chk("load_x_565", 32'(ball_x), 565);
    chk("load_y_240", 32'(ball_y), 240);
    tick();
    chk("bounce_x_max", 32'(ball_x), 569);
    chk("bounce_y", 32'(ball_y), 237);
    rd(3'd1, rv); chk("bounce_dx", 32'(rv), 32'h0F6);
    tick();
    chk("after_bounce_x", 32'(ball_x), 559);
    rd(3'd4, rv); chk("rd_x_hi", 32'(rv), 2);
    rd(3'd3, rv); chk("rd_x_lo", 32'(rv), 32'h2F);

    // Load with clamp
    wr(3'd3, 8'd5);
    wr(3'd4, 8'd0);
    wr(3'd5, 8'h84);
    wr(3'd6, 8'h03);
    wr(3'd0, 8'h03);
    rd(3'd0, rv); chk("ctrl_pending", 32'(rv), 3);
    tick();
    chk("clamp_x", 32'(ball_x), 70);
    chk("clamp_y", 32'(ball_y), 409);
    rd(3'd0, rv); chk("ctrl_cleared", 32'(rv), 1);
    rd(3'd1, rv); chk("clamp_dx_kept", 32'(rv), 32'h0F6);
    rd(3'd2, rv); chk("clamp_dy_kept", 32'(rv), 32'h0FD);
    rd(3'd6, rv); chk("rd_y_hi", 32'(rv), 1);
    rd(3'd5, rv); chk("rd_y_lo", 32'(rv), 32'h99);
    wr(3'd0, 8'h00);
    tick();
    chk("disabled_x", 32'(ball_x), 70);
    chk("disabled_y", 32'(ball_y), 409);

    // Saturation, then DX write colliding with a left-edge bounce
    wr(3'd1, 8'h80);
    rd(3'd1, rv); chk("sat_dx", 32'(rv), 32'h81);
    wr(3'd0, 8'h01);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 8'd4;
    cyc();
    chipselect = 1'b0; write = 1'b0;
    chk("coll_x_min", 32'(ball_x), 70);
    chk("coll_y", 32'(ball_y), 406);
    rd(3'd1, rv); chk("coll_dx_write_wins", 32'(rv), 4);

    // Counter wrap from a clean reset
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cyc();
    tick();
    rd(3'd7, rv); chk("fcnt_one", 32'(rv), 1);
    for (int i = 0; i < 255; i++) tick();
    rd(3'd7, rv); chk("fcnt_wrap", 32'(rv), 0);
    chk("wrap_x_static", 32'(ball_x), 320);

    // Reset asserted during STEP
    wr(3'd1, 8'd5);
    wr(3'd0, 8'h01);
    rd(3'd1, rv);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    chk("mid_busy_hi", 32'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_x", 32'(ball_x), 320);
    chk("mid_y", 32'(ball_y), 240);
    chk("mid_readdata", 32'(readdata), 0);
    #2 reset = 1'b0;
    cyc();
    chk("mid_x_after", 32'(ball_x), 320);
    rd(3'd1, rv); chk("mid_dx", 32'(rv), 0);
    rd(3'd0, rv); chk("mid_ctrl", 32'(rv), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_ball_motion.md
# vga_ball_motion

Frame-synchronous ball position engine that feeds the coordinate inputs of the VGA ball renderer. Software programs velocity and staged position over the same 8-bit Avalon-MM slave style as the renderer. The block advances the ball once per frame during vertical blank and reflects it off the visible-area edges. Outputs change only inside blanking, so the renderer never sees a half-updated (torn) coordinate.

## Interface
- `H_ACTIVE`, default 640: visible columns.
- `V_ACTIVE`, default 480: visible rows.
- `RADIUS`, default 70: ball radius in pixels; sets the bounce bounds.
- `clk` in 1: 50 MHz system clock.
- `reset` in 1: asynchronous, active-high reset; clock is `clk`.
- `chipselect` in 1: slave select.
- `write` in 1: write strobe.
- `read` in 1: read strobe.
- `address` in 3: register index.
- `writedata` in 8: write data.
- `readdata` out 8: read data, registered.
- `frame_tick` in 1: one-cycle pulse at the start of vertical blank, from the VGA counter stage.
- `ball_x` out 10: ball centre column, 0..H_ACTIVE-1.
- `ball_y` out 10: ball centre row, 0..V_ACTIVE-1.
- `busy` out 1: high during the STEP cycle.

## Operation
- **Bounds.** XMIN = RADIUS, XMAX = H_ACTIVE-1-RADIUS. YMIN = RADIUS, YMAX = V_ACTIVE-1-RADIUS.
- **Register map** (write when chipselect && write):
  - 0 CTRL: bit0 enable. Bit1 load: self-clearing request that sets load_pending.
  - 1 DX: signed velocity, px/frame.
  - 2 DY: signed velocity, px/frame.
  - 3 SX[7:0], 4 SX[9:8]: staged x.
  - 5 SY[7:0], 6 SY[9:8]: staged y.
  - 7: write ignored.
  - A written value of -128 to DX or DY is stored as -127.
- **Read map:**
  - 0: {6'b0, load_pending, enable}
  - 1: DX
  - 2: DY
  - 3: ball_x[7:0]
  - 4: {6'b0, ball_x[9:8]}
  - 5: ball_y[7:0]
  - 6: {6'b0, ball_y[9:8]}
  - 7: frame_cnt, an 8-bit counter that increments on every frame_tick and wraps 255→0.
- **FSM states:**
  - IDLE: frame_tick → STEP. frame_tick is ignored if already in STEP.
  - STEP: position update, then → IDLE unconditionally.
- **STEP update, load_pending=1** (load has priority over enable):
  - ball_x ← clamp(SX, XMIN, XMAX); ball_y ← clamp(SY, YMIN, YMAX).
  - load_pending ← 0; DX and DY unchanged.
- **STEP update, load_pending=0, enable=1**, per axis with 12-bit signed arithmetic:
  - n = pos + sext(d).
  - If n < MIN: pos ← MIN and d ← -d.
  - Else if n > MAX: pos ← MAX and d ← -d.
  - Else pos ← n.
- **STEP update, otherwise:** position holds.
- **Simultaneous write and bounce.** A software write to DX/DY on the STEP edge wins over the bounce negation. A CTRL load write on the STEP edge sets load_pending for the next frame.

## Timing
- **Reset values:**
  - ball_x=H_ACTIVE/2 (320), ball_y=V_ACTIVE/2 (240).
  - DX=DY=0; SX=320, SY=240.
  - enable=0, load_pending=0, frame_cnt=0.
  - readdata=0, busy=0, FSM=IDLE.
- **Reset mid-STEP:** returns to the reset values immediately, regardless of clock.
- **Position latency:** frame_tick sampled high at edge k → FSM=STEP and busy=1 after edge k. ball_x/ball_y update at edge k+1, busy=0 after k+1.
- **frame_cnt:** increments at edge k.
- **readdata:** valid the cycle after chipselect && read (1-cycle latency). It holds otherwise.
- **Register writes:** take effect at the write edge.
- **Update window:** both coordinates change on the same edge and only in STEP, i.e. inside vertical blank.

## Structure
- **Shared package `vga_pkg`:**
  - Address constants ADDR_CTRL..ADDR_FCNT.
  - FSM enum {IDLE, STEP}.
  - Default H_ACTIVE/V_ACTIVE.
- **Sub-module `axis_step`** (parameter MIN, MAX), instantiated twice, once per axis:
  - Inputs: pos, d.
  - Outputs: next_pos, next_d.
  - Purely combinational reflect/clamp.

## Test plan
- **Reset:** assert reset with no clock → ball=(320,240), readdata=0, busy=0; addr 7 read → 0.
- **Free motion:** DX=5, DY=-3, enable=1, one frame_tick → ball=(325,237) two edges after the tick; busy high exactly one cycle.
- **Right-edge bounce:** load SX=565, DX=10, tick, then tick → ball_x=569 (XMAX) and DX read = -10; next tick → 559.
- **Load with clamp:** SX=5, SY=900, CTRL=0x3, tick → ball=(70,409), load_pending=0, DX/DY unchanged. With enable=0 a further tick leaves the position unchanged.
- **Saturation and collision:** write DX=-128 → reads -127 (0x81). A write of DX=4 on the same edge as a bounce → DX=4.
- **Counter wrap:** 256 ticks → addr 7 reads 0. A reset asserted during STEP → reset values, FSM IDLE.
